// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, oversample edge/bit counting,
// deserialization, parity and stop checking for a majority-vote sampler.
module uart_rx_ctrl #(
  parameter int DATA_W = 8,
  parameter int PRE_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic [PRE_W-1:0]  Prescale,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              sampled_bit,
  output logic              sample_en,
  output logic [4:0]        edge_count,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err,
  output logic              strt_glitch,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t             state_r;
  logic [4:0]         edge_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [DATA_W-1:0]  shift_r;
  logic [DATA_W-1:0]  p_data_r;
  logic               data_valid_r;
  logic               par_err_r;
  logic               stp_err_r;
  logic               strt_glitch_r;
  logic               busy_r;

  logic [PRE_W-1:0]   prescale_m1_s;
  logic               pre_legal_s;
  logic               last_s;

  // Returns 1 when the received parity bit disagrees with the data (PAR_TYP: 0 even, 1 odd).
  function automatic logic par_mismatch(input logic [DATA_W-1:0] data,
                                        input logic              par_bit,
                                        input logic              odd);
    return par_bit ^ (^data) ^ odd;
  endfunction

  assign prescale_m1_s = Prescale - PRE_W'(1);
  assign pre_legal_s   = (Prescale == PRE_W'(8)) || (Prescale == PRE_W'(16)) ||
                         (Prescale == PRE_W'(32));
  // Decisions are taken on the final oversample edge of each bit period.
  assign last_s        = ({{(PRE_W-5){1'b0}}, edge_cnt_r} == prescale_m1_s);

  // Frame FSM with edge/bit counters and all registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      edge_cnt_r    <= 5'd0;
      bit_cnt_r     <= '0;
      shift_r       <= '0;
      p_data_r      <= '0;
      data_valid_r  <= 1'b0;
      par_err_r     <= 1'b0;
      stp_err_r     <= 1'b0;
      strt_glitch_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      data_valid_r  <= 1'b0;
      strt_glitch_r <= 1'b0;

      if (state_r == ST_IDLE) begin
        edge_cnt_r <= 5'd0;
      end else if (last_s) begin
        edge_cnt_r <= 5'd0;
      end else begin
        edge_cnt_r <= edge_cnt_r + 5'd1;
      end

      case (state_r)
        ST_IDLE: begin
          if (!RX_IN && pre_legal_s) begin
            state_r   <= ST_START;
            busy_r    <= 1'b1;
            par_err_r <= 1'b0;
            stp_err_r <= 1'b0;
          end
        end
        ST_START: begin
          if (last_s) begin
            if (sampled_bit) begin
              state_r       <= ST_IDLE;
              busy_r        <= 1'b0;
              strt_glitch_r <= 1'b1;
            end else begin
              state_r   <= ST_DATA;
              bit_cnt_r <= '0;
            end
          end
        end
        ST_DATA: begin
          if (last_s) begin
            shift_r[bit_cnt_r] <= sampled_bit;
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= '0;
              state_r   <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (last_s) begin
            par_err_r <= par_mismatch(shift_r, sampled_bit, PAR_TYP);
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (last_s) begin
            stp_err_r <= ~sampled_bit;
            // P_DATA only ever reflects a clean frame.
            if (sampled_bit && !par_err_r) begin
              p_data_r     <= shift_r;
              data_valid_r <= 1'b1;
            end
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_en   = busy_r;
  assign busy        = busy_r;
  assign edge_count  = edge_cnt_r;
  assign P_DATA      = p_data_r;
  assign data_valid  = data_valid_r;
  assign par_err     = par_err_r;
  assign stp_err     = stp_err_r;
  assign strt_glitch = strt_glitch_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames pushed with expected results,
// a negedge monitor checks every frame end (busy falling) against the queue.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit = 1'b1;
  logic       sample_en;
  logic [4:0] edge_count;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;
  logic       busy;

  typedef struct {
    logic       glitch;
    logic       dv;
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         start;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_dv = 0;
  int   prev_dv = 0;
  logic busy_d  = 1'b0;
  logic s0 = 1'b1, s1 = 1'b1;
  logic busy_seen;
  logic [4:0] half_s;

  uart_rx_ctrl #(.DATA_W(8), .PRE_W(6)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .sample_en(sample_en),
    .edge_count(edge_count), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampler model: three mid-bit samples, majority vote ready before the last edge.
  assign half_s = Prescale[5:1];
  always @(posedge clk) begin
    if (sample_en) begin
      if (edge_count == half_s - 5'd1) s0 <= RX_IN;
      if (edge_count == half_s) s1 <= RX_IN;
      if (edge_count == half_s + 5'd1)
        sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every busy fall is a frame end and is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (busy_d && !busy) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_frame_end: got frame end, expected none (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("data_valid", data_valid, e.dv);
        chk("strt_glitch", strt_glitch, e.glitch);
        chk("P_DATA", P_DATA, e.data);
        chk("par_err", par_err, e.par);
        chk("stp_err", stp_err, e.stp);
        if (e.lat > 0) begin
          lat = cyc - e.start;
          n_tests++;
          if (lat < e.lat - 1 || lat > e.lat + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d+-1", lat, e.lat);
          end
        end
      end
    end else begin
      if (data_valid) begin
        n_tests++; n_fail++;
        $display("FAIL stray_data_valid: got 1 outside frame end, expected 0 (cycle %0d)", cyc);
      end
      if (strt_glitch) begin
        n_tests++; n_fail++;
        $display("FAIL stray_strt_glitch: got 1 outside frame end, expected 0 (cycle %0d)", cyc);
      end
    end
    if (data_valid) begin
      prev_dv = last_dv;
      last_dv = cyc;
    end
    busy_d = busy;
  end

  // Called just after a posedge; holds b on the line for one bit period.
  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (int'(Prescale)) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic g, input logic dv, input logic [7:0] d,
                      input logic p, input logic s, input int lat);
    exp_t e;
    e.glitch = g; e.dv = dv; e.data = d; e.par = p; e.stp = s;
    e.start = cyc + 1; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                            input logic exp_dv, input logic [7:0] exp_data,
                            input logic exp_par, input logic exp_stp);
    push(1'b0, exp_dv, exp_data, exp_par, exp_stp, (10 + int'(PAR_EN)) * int'(Prescale));
    RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy_at_start", busy, 1'b1);
    chk("stp_err_clr_at_start", stp_err, 1'b0);
    chk("par_err_clr_at_start", par_err, 1'b0);
    repeat (int'(Prescale) - 2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
    RX_IN = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending frames, expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_P_DATA", P_DATA, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sample_en", sample_en, 1'b0);
    chk("rst_edge_count", edge_count, 5'd0);
    chk("rst_flags", {data_valid, par_err, stp_err, strt_glitch}, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Prescale 8, no parity, 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    wait_drain();

    // Prescale 16, even parity, 0x37 good then bad parity
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h37, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0);
    wait_drain();
    send_frame(8'h37, 1'b0, 1'b1, 1'b0, 8'h37, 1'b1, 1'b0);
    wait_drain();

    // Prescale 32, stop error then good 0xFF
    Prescale = 6'd32; PAR_EN = 1'b0;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8'h37, 1'b0, 1'b1);
    wait_drain();
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    wait_drain();

    // Prescale 8, three-cycle false start
    Prescale = 6'd8;
    push(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8);
    RX_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1 RX_IN = 1'b1;
    wait_drain();

    // Prescale 16, back-to-back 0x12, 0x34
    Prescale = 6'd16;
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0);
    wait_drain();
    n_tests++;
    if ((last_dv - prev_dv) < 159 || (last_dv - prev_dv) > 161) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, expected 160+-1", last_dv - prev_dv);
    end

    // Reset during DATA bit 4, then 0x5A
    push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; RX_IN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_P_DATA", P_DATA, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_sample_en", sample_en, 1'b0);
    chk("abort_edge_count", edge_count, 5'd0);
    chk("abort_flags", {data_valid, par_err, stp_err, strt_glitch}, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    wait_drain();

    // Illegal Prescale 10: line activity must be ignored
    Prescale = 6'd10;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      RX_IN = i[0];
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      @(posedge clk); #1;
    end
    RX_IN = 1'b1;
    chk("busy_illegal_prescale", busy_seen, 1'b0);
    chk("P_DATA_after_illegal", P_DATA, 8'h5A);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
